// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches and buffers the returned words for decode.
// Latency: a request in cycle N returns in N+1 and is visible at the head no earlier than N+2.
// Backpressure: a fetch is issued only while buffered plus in-flight entries leave room, so a response always has a slot.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req / imem_addr     fetch request and word-aligned byte address
//   imem_rdata               fetched word, one cycle after the request
//   redirect / redirect_pc   flush and restart fetch at redirect_pc (low two bits ignored)
//   out_valid / out_ready    head handshake towards decode
//   out_inst / out_pc        head instruction word and its address
//   occupancy                number of buffered entries
//   stall_cnt                saturating count of cycles decode was ready but starved
//                            (only when FETCH_QUEUE_PERF_EN is defined)
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]              stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] occ;
    logic             in_flight;
    logic [31:0]      in_flight_pc;
    logic [31:0]      fetch_pc;
    logic [OCC_W:0]   committed;
    logic             push;
    logic             pop;

    // The sub-word bits of a redirect target are meaningless for word fetch.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit rule: every slot is either holding a word or reserved for the
    // response already on its way, so a push can never find the buffer full.
    assign committed = {1'b0, occ} + {{OCC_W{1'b0}}, in_flight};
    assign imem_req  = !rst && !redirect && (committed < (OCC_W + 1)'(DEPTH));
    assign imem_addr = fetch_pc;

    // A response arriving in the redirect cycle belongs to the discarded path.
    assign push      = in_flight && !redirect;
    assign out_valid = !rst && !redirect && (occ != '0);
    assign pop       = out_valid && out_ready;

    assign out_inst  = inst_mem[head];
    assign out_pc    = pc_mem[head];
    assign occupancy = occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc     <= {RESET_PC[31:2], 2'b00};
            occ          <= '0;
            head         <= '0;
            tail         <= '0;
            in_flight    <= 1'b0;
            in_flight_pc <= '0;
        end else if (redirect) begin
            fetch_pc     <= {redirect_pc[31:2], 2'b00};
            occ          <= '0;
            head         <= '0;
            tail         <= '0;
            in_flight    <= 1'b0;
        end else begin
            // Address wraps naturally at the top of the 32-bit space.
            if (imem_req) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            in_flight    <= imem_req;
            in_flight_pc <= fetch_pc;
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (pop && !push) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            inst_mem[tail] <= imem_rdata;
            pc_mem[tail]   <= in_flight_pc;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_ready && !out_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    assert property (@(posedge clk) disable iff (rst)
        !(push && (occ == OCC_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  occupancy;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_cnt;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
`ifdef FETCH_QUEUE_PERF_EN
        .stall_cnt  (stall_cnt),
`endif
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: scoreboard of expected head PCs plus the in-flight request.
    logic [31:0] bq[$];
    logic        m_if    = 1'b0;
    logic [31:0] m_if_pc = 32'h0;
    logic [31:0] exp_pc  = RST_PC;
    logic [31:0] m_stall = 32'h0;
    int          since_rst = 0;
    bit          first_seen = 1'b0;

    // Memory responder state: request seen in the current cycle.
    logic        mreq  = 1'b0;
    logic [31:0] maddr = 32'h0;

    always @(posedge clk) begin
        #1;
        imem_rdata = mreq ? (maddr ^ KEY) : 32'h0BAD_0BAD;
    end

    always @(negedge clk) begin
        logic exp_req;
        logic exp_valid;
        exp_req   = !rst && !redirect && ((bq.size() + int'(m_if)) < DEPTH);
        exp_valid = !rst && !redirect && (bq.size() != 0);
        check("imem_req",  {31'b0, imem_req},  {31'b0, exp_req});
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        check("occupancy", {29'b0, occupancy}, bq.size());
        if (exp_req) check("imem_addr", imem_addr, exp_pc);
        if (exp_valid) begin
            check("out_pc",   out_pc,   bq[0]);
            check("out_inst", out_inst, bq[0] ^ KEY);
        end
`ifdef FETCH_QUEUE_PERF_EN
        check("stall_cnt", stall_cnt, m_stall);
        if (rst) m_stall = 32'h0;
        else if (out_ready && !exp_valid && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
        // First head entry must appear exactly two cycles after reset release.
        if (rst) begin
            since_rst  = 0;
            first_seen = 1'b0;
        end else begin
            if (out_valid && !first_seen) begin
                check("first_valid_cycle", since_rst, 2);
                first_seen = 1'b1;
            end
            since_rst++;
        end
        mreq  = imem_req;
        maddr = imem_addr;
        if (rst) begin
            bq.delete();
            m_if   = 1'b0;
            exp_pc = RST_PC;
        end else if (redirect) begin
            bq.delete();
            m_if   = 1'b0;
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (exp_valid && out_ready) void'(bq.pop_front());
            if (m_if) bq.push_back(m_if_pc);
            m_if = exp_req;
            if (exp_req) begin
                m_if_pc = exp_pc;
                exp_pc  = exp_pc + 32'd4;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_occ(input int target, input logic need_if);
        for (int i = 0; i < 30 && !(bq.size() == target && (!need_if || m_if)); i++) step(1);
        check("reach_occ", {29'b0, occupancy}, target);
    endtask

    initial begin
        logic [31:0] base;
        int          k;

        // Reset, then free-running fetch across the address wrap.
        rst = 1'b1; out_ready = 1'b1;
        step(3);
        check("rst_occ", {29'b0, occupancy}, 0);
        rst = 1'b0;
        step(8);

        // Decode stalled right after reset: buffer fills and fetching stops.
        rst = 1'b1; out_ready = 1'b0;
        step(2);
        rst = 1'b0;
        step(10);
        check("stall_full_occ", {29'b0, occupancy}, 4);
        check("stall_no_req",   {31'b0, imem_req}, 0);
        check("stall_head_pc",  out_pc, RST_PC);
        check("stall_head_inst", out_inst, RST_PC ^ KEY);
        out_ready = 1'b1;
        step(6);

        // Flush with three buffered and one in flight while decode is stalled.
        redirect = 1'b1; redirect_pc = 32'h0000_2000;
        step(1);
        redirect = 1'b0; out_ready = 1'b0;
        wait_occ(3, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step(1);
        redirect = 1'b0; out_ready = 1'b1;
        base = m_stall;
        @(negedge clk);
        check("redir_occ",  {29'b0, occupancy}, 0);
        check("redir_addr", imem_addr, 32'h0000_0100);
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("redir_valid",   {31'b0, out_valid}, 1);
        check("redir_latency", k, 2);
        check("redir_pc",      out_pc, 32'h0000_0100);
`ifdef FETCH_QUEUE_PERF_EN
        check("redir_stall_delta", stall_cnt, base + 32'd2);
`endif
        step(4);

        // Back-to-back redirects: only the last target survives.
        redirect = 1'b1; redirect_pc = 32'h0000_4444;
        step(1);
        redirect_pc = 32'h0000_8001;
        step(1);
        redirect = 1'b0;
        step(8);

        // Random decode backpressure with occasional redirects.
        for (int i = 0; i < 300; i++) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            step(1);
        end
        redirect = 1'b0;

        // Reset mid-operation with two entries buffered.
        redirect = 1'b1; redirect_pc = 32'h0000_0400;
        step(1);
        redirect = 1'b0; out_ready = 1'b0;
        wait_occ(2, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'b0, out_valid}, 0);
        check("mid_rst_occ",   {29'b0, occupancy}, 0);
        check("mid_rst_addr",  imem_addr, RST_PC);
        step(1);
        out_ready = 1'b1;
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
